// File: rtl/cdu_seq_pkg.sv
// cdu_seq_pkg: shared FSM states and saturating backlog arithmetic for the increment sequencer
package cdu_seq_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_OFFER, ST_GAP} state_e;
  function automatic int sat_max(input int bw);
    return (1 << (bw - 1)) - 1;
  endfunction
  function automatic int sat_min(input int bw);
    return -sat_max(bw);
  endfunction
  function automatic int sat_add(input int a, input int d, input int bw);
    int s;
    s = a + d;
    return s > sat_max(bw) ? sat_max(bw) : s < sat_min(bw) ? sat_min(bw) : s;
  endfunction
endpackage

// File: rtl/cdu_rr_pick.sv
// cdu_rr_pick: first set request at or after ptr, wrapping modulo NCH
module cdu_rr_pick #(
  parameter int NCH = 5,
  parameter int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [CW-1:0]  grant,
  output logic           found
);
  logic [CW-1:0] idx;
  // scan from farthest to nearest so the nearest hit wins
  always_comb begin
    grant = '0;
    idx   = '0;
    found = |req;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = CW'((int'(ptr) + k) % NCH);
      if (req[idx]) grant = idx;
    end
  end
endmodule

// File: rtl/cdu_incr_sequencer.sv
// cdu_incr_sequencer: per-channel signed backlogs serialised round-robin into +/- pulses
module cdu_incr_sequencer
  import cdu_seq_pkg::*;
#(
  parameter int NCH = 5,
  parameter int BW  = 4,
  parameter int GAP = 2,
  parameter int CW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] up_req,
  input  logic [NCH-1:0] dn_req,
  input  logic [NCH-1:0] zero,
  output logic           out_valid,
  output logic [CW-1:0]  out_chan,
  output logic           out_dir,
  input  logic           out_ready,
  output logic [NCH-1:0] ovf,
  output logic           busy
);
  localparam int GW = $clog2(GAP + 1) + 1;
  state_e        state_q, state_d;
  logic [CW-1:0] rr_q, rr_d, out_chan_q, out_chan_d, grant;
  logic          out_valid_q, out_valid_d, out_dir_q, out_dir_d, busy_q, busy_d, found;
  logic [GW-1:0] gap_q, gap_d;
  logic [NCH-1:0] nz, nz_d, neg;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic signed [BW-1:0] bl_q, bl_d;
    logic ov_q, ov_d, acc;
    int d, s;
    assign acc = out_valid_q & out_ready & (out_chan_q == CW'(i));
    // net change this cycle, saturated; a clipped change marks sticky overflow; zero wins over everything
    always_comb begin
      d = int'(up_req[i]) - int'(dn_req[i]) - (acc ? (out_dir_q ? 1 : -1) : 0);
      s = sat_add(int'(bl_q), d, BW);
      bl_d = zero[i] ? '0 : BW'(s);
      ov_d = zero[i] ? 1'b0 : ov_q | (s != int'(bl_q) + d);
    end
    // backlog and overflow registers
    always_ff @(posedge clk) begin
      if (rst) begin
        bl_q <= '0;
        ov_q <= 1'b0;
      end else begin
        bl_q <= bl_d;
        ov_q <= ov_d;
      end
    end
    assign nz[i]   = bl_q != '0;
    assign nz_d[i] = bl_d != '0;
    assign neg[i]  = bl_q[BW-1];
    assign ovf[i]  = ov_q;
  end
  cdu_rr_pick #(.NCH(NCH), .CW(CW)) u_pick (
    .req  (nz),
    .ptr  (rr_q),
    .grant(grant),
    .found(found)
  );
  // offer/accept/gap sequencing; an offer, once latched, is held until accepted
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    out_dir_d   = out_dir_q;
    gap_d       = gap_q;
    case (state_q)
      ST_IDLE: if (found) begin
        state_d     = ST_OFFER;
        out_valid_d = 1'b1;
        out_chan_d  = grant;
        out_dir_d   = !neg[grant];
      end
      ST_OFFER: if (out_ready) begin
        state_d     = GAP > 0 ? ST_GAP : ST_IDLE;
        out_valid_d = 1'b0;
        rr_d        = out_chan_q == CW'(NCH - 1) ? '0 : out_chan_q + 1'b1;
        gap_d       = '0;
      end
      ST_GAP: begin
        gap_d   = gap_q + 1'b1;
        state_d = gap_q == GW'(GAP - 1) ? ST_IDLE : ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = |nz_d | out_valid_d;
  end
  // sequencer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_dir_q   <= 1'b0;
      gap_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_dir_q   <= out_dir_d;
      gap_q       <= gap_d;
      busy_q      <= busy_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_dir   = out_dir_q;
  assign busy      = busy_q;
endmodule
